// File: rtl/laser_host.sv
// Host-side driver/checker for the LASER engine: loads a 40-point set, resets the engine,
// streams points on x/y, waits for done, captures the circle centres and scores coverage.
module laser_host #(
  parameter int NPTS       = 40,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 4096,
  parameter int RADIUS_SQ  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld_en,
  input  logic [5:0] ld_addr,
  input  logic [3:0] ld_x,
  input  logic [3:0] ld_y,
  input  logic       start,
  output logic       dut_rst,
  output logic [3:0] x,
  output logic [3:0] y,
  input  logic       dut_done,
  input  logic [3:0] dut_c1x,
  input  logic [3:0] dut_c1y,
  input  logic [3:0] dut_c2x,
  input  logic [3:0] dut_c2y,
  output logic       busy,
  output logic       result_valid,
  output logic       timed_out,
  output logic [5:0] score,
  output logic [3:0] r_c1x,
  output logic [3:0] r_c1y,
  output logic [3:0] r_c2x,
  output logic [3:0] r_c2y
);

  typedef enum logic [2:0] {
    S_IDLE, S_DUT_RESET, S_STREAM, S_WAIT, S_SCORE, S_REPORT
  } state_t;

  localparam logic [5:0]  RST_LAST  = 6'(RST_CYCLES - 1);
  localparam logic [5:0]  PT_LAST   = 6'(NPTS - 1);
  localparam logic [5:0]  PT_COUNT  = 6'(NPTS);
  localparam logic [11:0] WAIT_LAST = 12'(TIMEOUT - 1);
  localparam logic [8:0]  RAD_SQ    = 9'(RADIUS_SQ);

  state_t      state, state_nxt;
  logic [5:0]  idx;
  logic [5:0]  idx_inc;
  logic [11:0] wcnt;
  logic [5:0]  acc;
  logic        cov;
  logic [3:0]  px [NPTS];
  logic [3:0]  py [NPTS];

  function automatic logic in_circle(input logic [3:0] ax, input logic [3:0] ay,
                                     input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] dx, dy;
    logic [7:0] sx, sy;
    logic [8:0] d2;
    dx = (ax >= cx) ? ax - cx : cx - ax;
    dy = (ay >= cy) ? ay - cy : cy - ay;
    sx = {4'd0, dx} * {4'd0, dx};
    sy = {4'd0, dy} * {4'd0, dy};
    d2 = {1'b0, sx} + {1'b0, sy};
    return d2 <= RAD_SQ;
  endfunction

  assign idx_inc = idx + 6'd1;
  assign cov = in_circle(px[idx], py[idx], r_c1x, r_c1y) |
               in_circle(px[idx], py[idx], r_c2x, r_c2y);

  // Point buffer is deliberately outside the reset domain so a reset keeps the loaded job.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && ld_en && ld_addr < PT_COUNT) begin
      px[ld_addr] <= ld_x;
      py[ld_addr] <= ld_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = S_DUT_RESET;
      S_DUT_RESET: if (idx == RST_LAST) state_nxt = S_STREAM;
      S_STREAM:    if (idx == PT_LAST) state_nxt = S_WAIT;
      S_WAIT: begin
        if (dut_done)                state_nxt = S_SCORE;
        else if (wcnt == WAIT_LAST)  state_nxt = S_REPORT;
      end
      S_SCORE:     if (idx == PT_LAST) state_nxt = S_REPORT;
      S_REPORT:    state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      wcnt         <= '0;
      acc          <= '0;
      dut_rst      <= 1'b1;
      x            <= '0;
      y            <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      timed_out    <= 1'b0;
      score        <= '0;
      r_c1x        <= '0;
      r_c1y        <= '0;
      r_c2x        <= '0;
      r_c2y        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          idx <= '0;
          if (start) begin
            busy         <= 1'b1;
            result_valid <= 1'b0;
            timed_out    <= 1'b0;
            score        <= '0;
            r_c1x        <= '0;
            r_c1y        <= '0;
            r_c2x        <= '0;
            r_c2y        <= '0;
          end
        end
        S_DUT_RESET: begin
          if (idx == RST_LAST) begin
            idx     <= '0;
            dut_rst <= 1'b0;
            x       <= px[0];
            y       <= py[0];
          end else begin
            idx <= idx_inc;
          end
        end
        // x/y are registered one index ahead so cycle k of the stream carries point k.
        S_STREAM: begin
          if (idx == PT_LAST) begin
            wcnt <= '0;
          end else begin
            idx <= idx_inc;
            x   <= px[idx_inc];
            y   <= py[idx_inc];
          end
        end
        S_WAIT: begin
          if (dut_done) begin
            r_c1x <= dut_c1x;
            r_c1y <= dut_c1y;
            r_c2x <= dut_c2x;
            r_c2y <= dut_c2y;
            idx   <= '0;
            acc   <= '0;
          end else if (wcnt == WAIT_LAST) begin
            timed_out    <= 1'b1;
            score        <= '0;
            r_c1x        <= '0;
            r_c1y        <= '0;
            r_c2x        <= '0;
            r_c2y        <= '0;
            result_valid <= 1'b1;
            busy         <= 1'b0;
          end else begin
            wcnt <= wcnt + 12'd1;
          end
        end
        S_SCORE: begin
          acc <= acc + {5'd0, cov};
          idx <= idx_inc;
          if (idx == PT_LAST) begin
            score        <= acc + {5'd0, cov};
            result_valid <= 1'b1;
            busy         <= 1'b0;
          end
        end
        S_REPORT: begin
          dut_rst <= 1'b1;
        end
        default: begin
          dut_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_laser_host.sv
// Directed bench for laser_host: stream order, coverage scoring, boundaries, timeout,
// ignored commands while busy, and asynchronous reset mid-job.
module tb_laser_host;

  localparam int NPTS    = 40;
  localparam int TIMEOUT = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ld_en = 1'b0;
  logic [5:0] ld_addr = '0;
  logic [3:0] ld_x = '0, ld_y = '0;
  logic       start = 1'b0;
  logic       dut_rst;
  logic [3:0] x, y;
  logic       dut_done = 1'b0;
  logic [3:0] dut_c1x = '0, dut_c1y = '0, dut_c2x = '0, dut_c2y = '0;
  logic       busy, result_valid, timed_out;
  logic [5:0] score;
  logic [3:0] r_c1x, r_c1y, r_c2x, r_c2y;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] ex [NPTS];
  logic [3:0] ey [NPTS];

  laser_host dut (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_x(ld_x), .ld_y(ld_y),
    .start(start), .dut_rst(dut_rst), .x(x), .y(y), .dut_done(dut_done),
    .dut_c1x(dut_c1x), .dut_c1y(dut_c1y), .dut_c2x(dut_c2x), .dut_c2y(dut_c2y),
    .busy(busy), .result_valid(result_valid), .timed_out(timed_out), .score(score),
    .r_c1x(r_c1x), .r_c1y(r_c1y), .r_c2x(r_c2x), .r_c2y(r_c2y)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (n_checks=%0d)", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pt(input int i, input logic [3:0] px, input logic [3:0] py);
    ld_en = 1'b1; ld_addr = 6'(i); ld_x = px; ld_y = py;
    ex[i] = px; ey[i] = py;
    tick();
    ld_en = 1'b0;
  endtask

  // Starts a job, checks the reset window and stream order, optionally injecting
  // START+LD_EN during the stream. Returns in the first WAIT cycle.
  task automatic run_to_wait(input int inject_at);
    start = 1'b1;
    tick();
    start = 1'b0;
    ld_en = 1'b0;
    check("busy_start", busy, 1);
    check("rv_clear", result_valid, 0);
    check("rst_hi0", dut_rst, 1);
    tick();
    check("rst_hi1", dut_rst, 1);
    tick();
    for (int k = 0; k < NPTS; k++) begin
      if (k == 0) check("rst_lo", dut_rst, 0);
      check($sformatf("stream%0d", k), {24'd0, x, y}, {24'd0, ex[k], ey[k]});
      if (k == inject_at) begin
        start = 1'b1; ld_en = 1'b1; ld_addr = 6'd0; ld_x = 4'd1; ld_y = 4'd1;
      end
      tick();
      start = 1'b0;
      ld_en = 1'b0;
    end
  endtask

  task automatic finish_job(input int delay, input logic [3:0] c1x, input logic [3:0] c1y,
                            input logic [3:0] c2x, input logic [3:0] c2y, input int exp_score);
    int n;
    repeat (delay) tick();
    check("busy_wait", busy, 1);
    dut_done = 1'b1; dut_c1x = c1x; dut_c1y = c1y; dut_c2x = c2x; dut_c2y = c2y;
    tick();
    dut_done = 1'b0;
    n = 0;
    while (!result_valid && n < 200) begin
      tick();
      n++;
    end
    check("score_latency", n, NPTS);
    check("score", score, exp_score);
    check("timed_out_lo", timed_out, 0);
    check("busy_report", busy, 0);
    check("r_c", {16'd0, r_c1x, r_c1y, r_c2x, r_c2y}, {16'd0, c1x, c1y, c2x, c2y});
    tick();
    check("rst_idle", dut_rst, 1);
    check("rv_hold", result_valid, 1);
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #11;
    check("rst_dut_rst", dut_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_rv", result_valid, 0);
    check("rst_to", timed_out, 0);
    check("rst_score", score, 0);
    check("rst_xy", {x, y}, 0);
    #10 rst_n = 1'b1;
    tick();

    // T1: stream order, two disjoint circles: 13 points near (0,0), 9 near (15,0)
    for (int i = 0; i < NPTS; i++) load_pt(i, 4'(i % 16), 4'(i / 16));
    run_to_wait(-1);
    finish_job(3, 4'd0, 4'd0, 4'd15, 4'd0, 22);

    // T2: all points at the shared centre
    for (int i = 0; i < NPTS; i++) load_pt(i, 4'd5, 4'd5);
    run_to_wait(-1);
    finish_job(0, 4'd5, 4'd5, 4'd5, 4'd5, 40);

    // T3: radius boundary; point 3 is written in the same cycle as START
    load_pt(0, 4'd9, 4'd5);
    load_pt(1, 4'd5, 4'd1);
    load_pt(2, 4'd7, 4'd8);
    for (int i = 4; i < NPTS; i++) load_pt(i, 4'd15, 4'd15);
    ld_en = 1'b1; ld_addr = 6'd3; ld_x = 4'd8; ld_y = 4'd8;
    ex[3] = 4'd8; ey[3] = 4'd8;
    run_to_wait(-1);
    finish_job(1, 4'd5, 4'd5, 4'd5, 4'd5, 3);

    // T5: START/LD_EN mid-stream are ignored
    run_to_wait(10);
    finish_job(0, 4'd5, 4'd5, 4'd5, 4'd5, 3);

    // T4: DONE never arrives
    run_to_wait(-1);
    n = 0;
    while (!timed_out && n < TIMEOUT + 100) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, TIMEOUT);
    check("timeout_rv", result_valid, 1);
    check("timeout_score", score, 0);
    check("timeout_rc", {16'd0, r_c1x, r_c1y, r_c2x, r_c2y}, 0);
    check("timeout_busy", busy, 0);
    tick();
    check("timeout_hold", timed_out, 1);

    // T6: asynchronous reset in WAIT, then a clean job on the retained buffer
    run_to_wait(-1);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_dut_rst", dut_rst, 1);
    check("arst_xy", {x, y}, 0);
    check("arst_to", timed_out, 0);
    #4 rst_n = 1'b1;
    tick();
    run_to_wait(-1);
    finish_job(2, 4'd5, 4'd5, 4'd5, 4'd5, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
